// File: rtl/fpmult_pkg.sv
// Shared types and helpers for the parametrised serial-load FP multiplier.
// Optional macro FPMULT_FLAGS_EN adds the IEEE exception flag output.
package fpmult_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_MUL,
        S_NORM,
        S_PACK
    } state_e;

    typedef enum logic [1:0] {
        C_ZERO,
        C_NORM,
        C_INF,
        C_NAN
    } cls_e;

    function automatic int bias(int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic logic [63:0] qnan(int ew, int mw);
        return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    endfunction

    // Subnormals fall into C_ZERO: inputs are flushed to zero.
    function automatic cls_e classify(logic e_zero, logic e_ones, logic f_nz);
        if (e_ones) return f_nz ? C_NAN : C_INF;
        if (e_zero) return C_ZERO;
        return C_NORM;
    endfunction

endpackage

// File: rtl/fp_mult_param_mant.sv
// Sequential shift-add mantissa multiplier: MAN_W+1 iterations after start_i.
// done_o is high during the cycle whose edge performs the final iteration.
module fp_mant_mul_seq #(
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [MAN_W:0]     a_i,
    input  logic [MAN_W:0]     b_i,
    output logic               done_o,
    output logic [2*MAN_W+1:0] prod_o
);
    localparam int M  = MAN_W + 1;
    localparam int CW = $clog2(M + 1);

    logic [2*M-1:0] mcand_q;
    logic [2*M-1:0] acc_q;
    logic [M-1:0]   mplr_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;

    assign done_o = run_q && (cnt_q == CW'(MAN_W));
    assign prod_o = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q <= {{M{1'b0}}, a_i};
            acc_q   <= '0;
            mplr_q  <= b_i;
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            if (mplr_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
            if (done_o) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_mult_param.sv
// Serial-load IEEE multiplier, generic widths, round-to-nearest-even.
// Define FPMULT_FLAGS_EN to add flags = {invalid, overflow, underflow, inexact}.
module fp_mult_param
    import fpmult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [EXP_W+MAN_W:0]       inBus,
    input  logic                       startFP,
    output logic [EXP_W+MAN_W:0]       resBus,
    output logic                       doneFP,
    output logic                       busy
`ifdef FPMULT_FLAGS_EN
    ,
    output logic [3:0]                 flags
`endif
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_S = EW'(bias(EXP_W));
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN   = W'(qnan(EXP_W, MAN_W));

    state_e                state_q;
    logic [W-1:0]          a_q;
    logic                  sign_q;
    logic signed [EW-1:0]  exp_q;
    cls_e                  spec_q;
    logic [MAN_W-1:0]      frac_q;
    logic                  guard_q;
    logic                  sticky_q;
    logic [W-1:0]          res_q;
    logic                  done_q;

    logic                  sa, sb;
    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    cls_e                  ca, cb;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = inBus;
    assign ca = classify(ea == '0, &ea, |fa);
    assign cb = classify(eb == '0, &eb, |fb);

    assign resBus = res_q;
    assign doneFP = done_q;
    assign busy   = (state_q != S_IDLE);

    logic                  mul_done;
    logic [2*MAN_W+1:0]    prod;

    fp_mant_mul_seq #(.MAN_W(MAN_W)) u_mant (
        .clk    (clk),
        .rst_n  (rst),
        .start_i(state_q == S_LOAD_B),
        .a_i    ({1'b1, fa}),
        .b_i    ({1'b1, fb}),
        .done_o (mul_done),
        .prod_o (prod)
    );

    cls_e                  spec_d;
    logic                  inv_d;
    logic signed [EW-1:0]  exp_d;

    always_comb begin
        spec_d = C_NORM;
        inv_d  = 1'b0;
        exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
        if (ca == C_NAN || cb == C_NAN) begin
            spec_d = C_NAN;
            inv_d  = (ca == C_NAN && !fa[MAN_W-1]) ||
                     (cb == C_NAN && !fb[MAN_W-1]);
        end else if ((ca == C_INF && cb == C_ZERO) ||
                     (ca == C_ZERO && cb == C_INF)) begin
            spec_d = C_NAN;
            inv_d  = 1'b1;
        end else if (ca == C_INF || cb == C_INF) begin
            spec_d = C_INF;
        end else if (ca == C_ZERO || cb == C_ZERO) begin
            spec_d = C_ZERO;
        end
    end

    logic                  msb;
    logic [MAN_W-1:0]      frac_n;
    logic                  guard_n;
    logic                  sticky_n;

    assign msb      = prod[2*MAN_W+1];
    assign frac_n   = msb ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
    assign guard_n  = msb ? prod[MAN_W] : prod[MAN_W-1];
    assign sticky_n = msb ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];

    logic                  inc;
    logic [MAN_W:0]        rnd;
    logic signed [EW-1:0]  exp_p;
    logic                  ovf, unf;
    logic [W-1:0]          res_p;

    always_comb begin
        inc   = guard_q & (sticky_q | frac_q[0]);
        rnd   = {1'b0, frac_q} + {{MAN_W{1'b0}}, inc};
        exp_p = exp_q + $signed({{(EW-1){1'b0}}, rnd[MAN_W]});
        ovf   = (exp_p >= EMAX_S);
        unf   = (exp_p <= 0);
        res_p = '0;
        unique case (spec_q)
            C_NAN:  res_p = QNAN;
            C_INF:  res_p = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            C_ZERO: res_p = {sign_q, {(W-1){1'b0}}};
            C_NORM: begin
                if (ovf)
                    res_p = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                else if (unf)
                    res_p = {sign_q, {(W-1){1'b0}}};
                else
                    res_p = {sign_q, exp_p[EXP_W-1:0], rnd[MAN_W-1:0]};
            end
        endcase
    end

`ifdef FPMULT_FLAGS_EN
    logic       inv_q;
    logic [3:0] flags_q;
    logic [3:0] flags_p;
    logic       nrm;

    assign nrm     = (spec_q == C_NORM);
    assign flags_p = {(spec_q == C_NAN) & inv_q,
                      nrm & ovf,
                      nrm & !ovf & unf,
                      nrm & (guard_q | sticky_q | ovf | unf)};
    assign flags   = flags_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            if (state_q == S_LOAD_B) inv_q <= inv_d;
            if (state_q == S_PACK) flags_q <= flags_p;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            spec_q   <= C_ZERO;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            res_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (startFP) state_q <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    a_q     <= inBus;
                    state_q <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    sign_q  <= sa ^ sb;
                    exp_q   <= exp_d;
                    spec_q  <= spec_d;
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    if (mul_done) state_q <= S_NORM;
                end
                S_NORM: begin
                    frac_q   <= frac_n;
                    guard_q  <= guard_n;
                    sticky_q <= sticky_n;
                    exp_q    <= exp_q + $signed({{(EW-1){1'b0}}, msb});
                    state_q  <= S_PACK;
                end
                S_PACK: begin
                    res_q   <= res_p;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_param.sv
// Scoreboard bench for fp_mult_param: single and half precision instances.
// Flag checks are compiled in when FPMULT_FLAGS_EN is defined.
module tb_fp_mult_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] inBus;
    logic        startFP;
    logic [31:0] resBus;
    logic        doneFP, busy;

    logic [15:0] inBusH;
    logic        startH;
    logic [15:0] resH;
    logic        doneH, busyH;

`ifdef FPMULT_FLAGS_EN
    logic [3:0]  flags, flagsH;
`endif

    fp_mult_param dut (
        .clk(clk), .rst(rst), .inBus(inBus), .startFP(startFP),
        .resBus(resBus), .doneFP(doneFP), .busy(busy)
`ifdef FPMULT_FLAGS_EN
        , .flags(flags)
`endif
    );

    fp_mult_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .inBus(inBusH), .startFP(startH),
        .resBus(resH), .doneFP(doneH), .busy(busyH)
`ifdef FPMULT_FLAGS_EN
        , .flags(flagsH)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && doneFP) begin
            if (q32.size() == 0) begin
                chk("done32_unexpected", 32'd1, 32'd0);
            end else begin
                e = q32.pop_front();
                chk("res32", resBus, e.res);
                chk("lat32", cyc, e.cyc);
`ifdef FPMULT_FLAGS_EN
                chk("flags32", {28'd0, flags}, {28'd0, e.fl});
`endif
            end
        end
        if (rst && doneH) begin
            if (q16.size() == 0) begin
                chk("done16_unexpected", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                chk("res16", {16'd0, resH}, e.res);
                chk("lat16", cyc, e.cyc);
`ifdef FPMULT_FLAGS_EN
                chk("flags16", {28'd0, flagsH}, {28'd0, e.fl});
`endif
            end
        end
    end

    task automatic issue(input bit h, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] fl,
                         input bit keep, input bit push, output int e0);
        int lat;
        exp_t e;
        lat = h ? 15 : 28;
        e0  = cyc + 1;
        e.res = r;
        e.fl  = fl;
        e.cyc = e0 + lat;
        if (push) begin
            if (h) q16.push_back(e);
            else q32.push_back(e);
        end
        if (h) startH = 1'b1;
        else startFP = 1'b1;
        @(negedge clk);
        if (h) begin
            inBusH = a[15:0];
            startH = keep;
        end else begin
            inBus   = a;
            startFP = keep;
        end
        @(negedge clk);
        if (h) inBusH = b[15:0];
        else inBus = b;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy && !busyH) return;
            @(negedge clk);
        end
        chk("idle_timeout", {30'd0, busy, busyH}, 32'd0);
    endtask

    task automatic run(input bit h, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [3:0] fl);
        int e0;
        issue(h, a, b, r, fl, 1'b0, 1'b1, e0);
        wait_idle();
    endtask

    logic [31:0] va [14];
    logic [31:0] vb [14];
    logic [31:0] vr [14];
    logic [3:0]  vf [14];

    initial begin
        va[0]  = 32'h412B3333; vb[0]  = 32'h40200000; vr[0]  = 32'h41D60000; vf[0]  = 4'b0001;
        va[1]  = 32'hC0000000; vb[1]  = 32'h40400000; vr[1]  = 32'hC0C00000; vf[1]  = 4'b0000;
        va[2]  = 32'h7F800000; vb[2]  = 32'h00000000; vr[2]  = 32'h7FC00000; vf[2]  = 4'b1000;
        va[3]  = 32'hFF800000; vb[3]  = 32'h3F800000; vr[3]  = 32'hFF800000; vf[3]  = 4'b0000;
        va[4]  = 32'h7F000000; vb[4]  = 32'h7F000000; vr[4]  = 32'h7F800000; vf[4]  = 4'b0101;
        va[5]  = 32'h00800000; vb[5]  = 32'h00800000; vr[5]  = 32'h00000000; vf[5]  = 4'b0011;
        va[6]  = 32'hFFC12345; vb[6]  = 32'h40000000; vr[6]  = 32'h7FC00000; vf[6]  = 4'b0000;
        va[7]  = 32'h7F800001; vb[7]  = 32'h3F800000; vr[7]  = 32'h7FC00000; vf[7]  = 4'b1000;
        va[8]  = 32'h80000000; vb[8]  = 32'h40000000; vr[8]  = 32'h80000000; vf[8]  = 4'b0000;
        va[9]  = 32'h00000001; vb[9]  = 32'h40000000; vr[9]  = 32'h00000000; vf[9]  = 4'b0000;
        va[10] = 32'h3F800001; vb[10] = 32'h3FC00000; vr[10] = 32'h3FC00002; vf[10] = 4'b0001;
        va[11] = 32'h3F800003; vb[11] = 32'h3FC00000; vr[11] = 32'h3FC00004; vf[11] = 4'b0001;
        va[12] = 32'h40400000; vb[12] = 32'h40400000; vr[12] = 32'h41100000; vf[12] = 4'b0000;
        va[13] = 32'hFF800000; vb[13] = 32'hFF800000; vr[13] = 32'h7F800000; vf[13] = 4'b0000;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        inBus   = '0;
        startFP = 1'b0;
        inBusH  = '0;
        startH  = 1'b0;
        #1;
        chk("rst_res", resBus, 32'd0);
        chk("rst_done", {31'd0, doneFP}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run(1'b0, va[i], vb[i], vr[i], vf[i]);

        // Back-to-back: start held through PACK launches the next op at once.
        issue(1'b0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000,
              1'b1, 1'b1, e0);
        while (cyc < e0 + 28) @(negedge clk);
        issue(1'b0, 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000,
              1'b0, 1'b1, e0);
        wait_idle();

        // A start pulse during MUL must not disturb the running op.
        issue(1'b0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000,
              1'b0, 1'b1, e0);
        repeat (3) @(negedge clk);
        startFP = 1'b1;
        @(negedge clk);
        startFP = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("pulse_no_restart", {31'd0, busy}, 32'd0);

        run(1'b1, 32'h3C00, 32'h4000, 32'h4000, 4'b0000);
        run(1'b1, 32'h3C00, 32'h3C00, 32'h3C00, 4'b0000);
        run(1'b1, 32'h7800, 32'h7800, 32'h7C00, 4'b0101);

        // Abort at E10: outputs clear immediately, no done afterwards.
        issue(1'b0, 32'h412B3333, 32'h40200000, 32'h0, 4'b0, 1'b0, 1'b0, e0);
        while (cyc < e0 + 9) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_res", resBus, 32'd0);
        chk("abort_done", {31'd0, doneFP}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_still_idle", {31'd0, busy}, 32'd0);
        chk("abort_res_held", resBus, 32'd0);

        @(negedge clk);
        chk("q32_drained", q32.size(), 32'd0);
        chk("q16_drained", q16.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_mult_param.md
Name: fp_mult_param

Overview:
Parametrised successor to the two-operand serial-load floating-point multiplier.
- Exponent/mantissa widths are generic: IEEE single by default, half or custom by parameter.
- Operands arrive one per clock on a shared bus after a start strobe. The mantissa product is formed by a sequential shift-add multiplier, then normalised and rounded to nearest-even.
- Adds IEEE special-case handling (zero, inf, NaN, overflow, underflow) that earlier generations lacked.
- Used as the FP multiply engine behind the datapath's bus-loaded arithmetic units.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- W, 1+EXP_W+MAN_W, word width; derived localparam, not user-set.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- inBus  in  W  operand bus: A, then B, on consecutive cycles.
- startFP  in  1  start request, sampled only in IDLE.
- resBus  out  W  result word, held stable until the next PACK.
- doneFP  out  1  one-cycle pulse when resBus is updated.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, resBus=0, doneFP=0, busy=0, all internal registers cleared. Reset asserted mid-operation aborts the operation; no doneFP is issued.
- FSM states: IDLE -> LOAD_A -> LOAD_B -> MUL -> NORM -> PACK -> IDLE.
- IDLE: startFP=1 at edge E0 moves to LOAD_A.
- LOAD_A: inBus captured as A at E1.
- LOAD_B: inBus captured as B at E2.
- MUL: MAN_W+1 shift-add iterations, one per edge (E3..E(MAN_W+3)), producing a 2*(MAN_W+1)-bit product.
- NORM: if product MSB=1, shift right 1 and exponent+1. Form guard bit and sticky bit.
- PACK: round to nearest-even, renormalise on mantissa carry-out, apply range checks, write resBus, pulse doneFP.
- Latency is fixed: doneFP rises at edge E0+MAN_W+5 (28 for defaults), including special cases.
- startFP is ignored in states other than IDLE. If startFP is still high when PACK returns to IDLE, the next edge starts a new operation.
- Sign: sA XOR sB, for all non-NaN results.
- Exponent: eA+eB-BIAS, where BIAS=2^(EXP_W-1)-1. Computed in an EXP_W+2-bit signed register so no wrap is possible.
- Subnormal inputs (exp=0, frac!=0) are treated as zero (flush-to-zero).
- Special cases, evaluated in LOAD_B/NORM, highest priority first:
  - any NaN input -> canonical qNaN: sign 0, exp all-ones, frac MSB=1, rest 0.
  - inf x zero -> canonical qNaN.
  - inf x finite or inf -> signed inf.
  - zero x finite -> signed zero.
- Overflow (final biased exp >= 2^EXP_W-1) -> signed inf.
- Underflow (final biased exp <= 0) -> signed zero; no subnormal output.

Optional Feature:
- Macro FPMULT_FLAGS_EN.
- When defined: adds output port flags[3:0] = {invalid, overflow, underflow, inexact}.
  - Registered in PACK together with resBus; reset value 0; held until the next PACK.
  - inexact = guard|sticky nonzero before rounding, or overflow/underflow occurred.
- When undefined: port absent; results identical.

Decomposition:
- Package fpmult_pkg:
  - state enum (IDLE, LOAD_A, LOAD_B, MUL, NORM, PACK).
  - operand-class enum (ZERO, NORM, INF, NAN).
  - functions: bias(EXP_W), qnan(EXP_W, MAN_W), classify().
- One sub-module, fp_mant_mul_seq: the sequential shift-add mantissa multiplier.
  - Parametrised by MAN_W; load/start/done handshake; fixed MAN_W+1 cycles.

Test Plan:
- Default params, A=0x412B3333 (10.7), B=0x40200000 (2.5) -> resBus=0x41D60000 (26.75), doneFP at E0+28, inexact=1.
- A=0xC0000000 (-2.0), B=0x40400000 (3.0) -> 0xC0C00000 (-6.0), flags=0. Repeat with startFP held high across PACK -> back-to-back operation starts with no idle gap.
- A=0x7F800000 (+inf), B=0x00000000 -> 0x7FC00000, invalid=1. A=0xFF800000, B=0x3F800000 -> 0xFF800000.
- A=B=0x7F000000 -> 0x7F800000, overflow=1. A=B=0x00800000 -> 0x00000000, underflow=1.
- startFP pulsed during MUL -> ignored, result unchanged. Reset driven low at E10 -> resBus=0, doneFP never pulses, busy=0 immediately.
- EXP_W=5, MAN_W=10: A=0x3C00 (1.0), B=0x4000 (2.0) -> 0x4000, doneFP at E0+15.
